// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a
// single-port synchronous RAM (cs/we/oe, shared tri-state data bus, read data
// available one clock after the address cycle).
//
// Transaction shapes:
//   write: IDLE -> WRITE -> DONE (ack) -> IDLE
//   read : IDLE -> RD_ADDR -> RD_DATA -> DONE (ack, rdata) -> IDLE
//
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0
// always wins a tie, port 1 may starve). Default build is round-robin.
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_ack,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e                  state_q;
    logic                    port_q;      // port id of the latched transaction
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic                    ram_cs_q;
    logic                    ram_we_q;
    logic                    ram_oe_q;
    logic                    p0_ack_q;
    logic                    p1_ack_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    logic                    last_q;      // last granted port, 1 = port 1
`endif

    logic                    req_any_s;
    logic                    grant_p1_s;
    logic                    sel_we_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;

    assign req_any_s = p0_req | p1_req;

    // Pick the winner among pending requests and mux its request fields.
    always_comb begin
        grant_p1_s = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
        if (p0_req) begin
            grant_p1_s = 1'b0;
        end else begin
            grant_p1_s = p1_req;
        end
`else
        if (p0_req && p1_req) begin
            grant_p1_s = ~last_q;
        end else if (p1_req) begin
            grant_p1_s = 1'b1;
        end else begin
            grant_p1_s = 1'b0;
        end
`endif
        if (grant_p1_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Sequencer FSM: state plus every registered output advance together,
    // so the RAM pins are glitch-free decodes of the state entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            port_q     <= 1'b0;
            wdata_q    <= {DATA_WIDTH{1'b0}};
            ram_addr_q <= {ADDR_WIDTH{1'b0}};
            ram_cs_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_oe_q   <= 1'b0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            rdata_q    <= {DATA_WIDTH{1'b0}};
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_any_s) begin
                        port_q     <= grant_p1_s;
                        wdata_q    <= sel_wdata_s;
                        ram_addr_q <= sel_addr_s;
                        ram_cs_q   <= 1'b1;
`ifndef RAM_ARB_FIXED_PRIO_EN
                        last_q     <= grant_p1_s;
`endif
                        if (sel_we_s) begin
                            state_q  <= ST_WRITE;
                            ram_we_q <= 1'b1;
                        end else begin
                            state_q  <= ST_RD_ADDR;
                            ram_we_q <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state_q  <= ST_DONE;
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    p0_ack_q <= ~port_q;
                    p1_ack_q <= port_q;
                end
                ST_RD_ADDR: begin
                    state_q  <= ST_RD_DATA;
                    ram_oe_q <= 1'b1;
                end
                ST_RD_DATA: begin
                    state_q  <= ST_DONE;
                    rdata_q  <= ram_data;
                    ram_cs_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    p0_ack_q <= ~port_q;
                    p1_ack_q <= port_q;
                end
                ST_DONE: begin
                    // Requests are deliberately not looked at here; a held
                    // req is evaluated in the following IDLE cycle.
                    state_q  <= ST_IDLE;
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    ram_oe_q <= 1'b0;
                    p0_ack_q <= 1'b0;
                    p1_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign p0_ack   = p0_ack_q;
    assign p1_ack   = p1_ack_q;
    assign rdata    = rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_cs   = ram_cs_q;
    assign ram_we   = ram_we_q;
    assign ram_oe   = ram_oe_q;

    // The bus is driven only in the WRITE state (ram_we high), which can
    // never coincide with ram_oe, so the RAM and this block never contend.
    assign ram_data = ram_we_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: RAM behavioural model, transaction-level
// reference model feeding a scoreboard queue, and a negedge monitor that
// compares every ack and bus cycle against the queued expectations.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   [2];
    logic       we_a  [2];
    logic [7:0] addr_a[2];
    logic [7:0] wd_a  [2];
    logic       p0_ack, p1_ack, ram_cs, ram_we, ram_oe;
    logic [7:0] rdata, ram_addr;
    tri1  [7:0] ram_data;

    // RAM model and preload port
    logic [7:0] mem [256];
    logic [7:0] dout = 8'h00;
    logic       pre_en = 1'b0;
    logic [7:0] pre_a = 8'h00;
    logic [7:0] pre_d = 8'h00;

    // Scoreboard
    typedef struct {
        int         port;
        int         cyc;
        bit         is_rd;
        logic [7:0] data;
    } exp_t;
    exp_t        exp_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  ref_mem [256];
    int          pcnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(req[0]), .p0_we(we_a[0]), .p0_addr(addr_a[0]), .p0_wdata(wd_a[0]),
        .p1_req(req[1]), .p1_we(we_a[1]), .p1_addr(addr_a[1]), .p1_wdata(wd_a[1]),
        .p0_ack(p0_ack), .p1_ack(p1_ack), .rdata(rdata),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_data(ram_data)
    );

    // Synchronous single-port RAM: write on cs&we, registered read otherwise.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_a] <= pre_d;
        end else if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_data;
            else        dout <= mem[ram_addr];
        end
    end
    assign ram_data = (ram_oe && !ram_we) ? dout : 8'bzzzzzzzz;

    task automatic check(input bit ok, input string nm, input int act, input int expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    endtask

    // Reference model: serialises accesses, one at a time, and predicts the
    // ack cycle (write: grant+2, read: grant+3) and read data.
    initial begin : ref_model
        int last = 1;
        int free_at = 0;
        int w;
        exp_t e;
        forever begin
            @(posedge clk);
            pcnt++;
            if (pre_en) ref_mem[pre_a] = pre_d;
            if (!rst_n) begin
                last = 1;
                free_at = pcnt + 1;
            end else if (pcnt >= free_at && (req[0] || req[1])) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                w = req[0] ? 0 : 1;
`else
                if (req[0] && req[1]) w = (last == 0) ? 1 : 0;
                else                  w = req[0] ? 0 : 1;
`endif
                last = w;
                e.port = w;
                e.is_rd = !we_a[w];
                e.data = 8'h00;
                if (we_a[w]) begin
                    ref_mem[addr_a[w]] = wd_a[w];
                    e.cyc = pcnt + 2;
                    free_at = pcnt + 3;
                    wr_q.push_back({addr_a[w], wd_a[w]});
                end else begin
                    e.data = ref_mem[addr_a[w]];
                    e.cyc = pcnt + 3;
                    free_at = pcnt + 4;
                end
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: mid-cycle sampling of acks and the RAM bus.
    initial begin : monitor
        int cur;
        exp_t e;
        logic [15:0] wv;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cur = pcnt + 1;
                if (p0_ack || p1_ack) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_ack", int'({p1_ack, p0_ack}), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check((p0_ack != p1_ack) && (p1_ack == (e.port == 1)), "ack_port",
                              int'({p1_ack, p0_ack}), (e.port == 1) ? 2 : 1);
                        check(cur == e.cyc, "ack_cycle", cur, e.cyc);
                        if (e.is_rd) check(rdata == e.data, "rdata", int'(rdata), int'(e.data));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc < cur) begin
                    e = exp_q.pop_front();
                    check(1'b0, "missing_ack", cur, e.cyc);
                end
                if (ram_we) begin
                    check(ram_cs && !ram_oe, "write_ctrl", int'({ram_cs, ram_oe}), 2);
                    if (wr_q.size() == 0) begin
                        check(1'b0, "unexpected_write", int'(ram_addr), 0);
                    end else begin
                        wv = wr_q.pop_front();
                        check(ram_addr == wv[15:8], "write_addr", int'(ram_addr), int'(wv[15:8]));
                        check(ram_data == wv[7:0], "write_data", int'(ram_data), int'(wv[7:0]));
                    end
                end else if (!ram_oe) begin
                    check(ram_data == 8'hFF, "bus_released", int'(ram_data), 8'hFF);
                end
            end
        end
    end

    task automatic cyc_wait(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_en = 1'b1;
        pre_a = a;
        pre_d = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic txn(input int p, input bit we, input logic [7:0] a, input logic [7:0] d,
                       input bit keep, output logic [7:0] rd);
        bit got = 1'b0;
        req[p] = 1'b1;
        we_a[p] = we;
        addr_a[p] = a;
        wd_a[p] = d;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if ((p == 0) ? p0_ack : p1_ack) begin
                got = 1'b1;
                break;
            end
        end
        check(got, "ack_timeout", int'(got), 1);
        rd = rdata;
        if (!keep) req[p] = 1'b0;
    endtask

    task automatic check_reset_vals();
        check(!p0_ack && !p1_ack, "rst_ack", int'({p1_ack, p0_ack}), 0);
        check(rdata == 8'h00, "rst_rdata", int'(rdata), 0);
        check(ram_addr == 8'h00, "rst_addr", int'(ram_addr), 0);
        check(!ram_cs && !ram_we && !ram_oe, "rst_ctrl", int'({ram_cs, ram_we, ram_oe}), 0);
        check(ram_data == 8'hFF, "rst_bus_released", int'(ram_data), 8'hFF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        wr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] r0, r1, r;
        bit got;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 8'h00; wd_a[i] = 8'h00;
        end
        // Reset values, RAM preload while held in reset
        #2;
        check_reset_vals();
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        @(negedge clk);
        rst_n = 1'b1;
        cyc_wait(2);
        check_reset_vals();

        // Port 0 write then read back
        txn(0, 1'b1, 8'h10, 8'hA5, 1'b0, r);
        txn(0, 1'b0, 8'h10, 8'h00, 1'b0, r);
        check(r == 8'hA5, "readback_A5", int'(r), 8'hA5);

        // Simultaneous reads straight out of reset: port 0 first
        preload(8'h01, 8'h11);
        preload(8'h02, 8'h22);
        do_reset();
        fork
            txn(0, 1'b0, 8'h01, 8'h00, 1'b0, r0);
            txn(1, 1'b0, 8'h02, 8'h00, 1'b0, r1);
        join
        check(r0 == 8'h11, "tie_read_p0", int'(r0), 8'h11);
        check(r1 == 8'h22, "tie_read_p1", int'(r1), 8'h22);

        // Both ports hold req continuously with writes
        fork
            begin
                logic [7:0] ra;
                for (int i = 0; i < 6; i++) txn(0, 1'b1, 8'(8'h40 + i), 8'($urandom), i < 5, ra);
            end
            begin
                logic [7:0] rb;
                for (int j = 0; j < 6; j++) txn(1, 1'b1, 8'(8'h50 + j), 8'($urandom), j < 5, rb);
            end
        join

        // Lone port 1 write to the top address
        cyc_wait(2);
        txn(1, 1'b1, 8'hFF, 8'h3C, 1'b0, r);

        // Randomised traffic on a small address window
        fork
            begin
                logic [7:0] ra;
                for (int i = 0; i < 30; i++) begin
                    cyc_wait($urandom_range(0, 3));
                    txn(0, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), 1'b0, ra);
                end
            end
            begin
                logic [7:0] rb;
                for (int j = 0; j < 30; j++) begin
                    cyc_wait($urandom_range(0, 3));
                    txn(1, 1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom), 1'b0, rb);
                end
            end
        join
        cyc_wait(3);

        // Reset pulsed during RD_DATA: abort with no ack, then recover
        req[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 8'h10;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ram_oe) begin
                got = 1'b1;
                break;
            end
        end
        check(got, "reach_rd_data", int'(got), 1);
        rst_n = 1'b0;
        exp_q.delete();
        wr_q.delete();
        req[0] = 1'b0;
        #1;
        check_reset_vals();
        repeat (3) @(negedge clk);
        check(!p0_ack && !p1_ack, "no_ack_in_reset", int'({p1_ack, p0_ack}), 0);
        rst_n = 1'b1;
        cyc_wait(1);
        txn(0, 1'b1, 8'h33, 8'h5A, 1'b0, r);
        txn(0, 1'b0, 8'h33, 8'h00, 1'b0, r);
        check(r == 8'h5A, "post_reset_read", int'(r), 8'h5A);

        cyc_wait(6);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
